pps_gate_controller: RTL
========================

# pps_gate_controller

Sequencer for the GPS-disciplined reference-clock counter. It watches the raw GPS 1PPS pin and opens and closes measurement gates spanning a programmable number of PPS intervals. It drives the clear, enable and latch strobes of the external free-running counter, and presents each latched result to the SPI register map through a valid/ack handshake. It also flags lost PPS, counter saturation and unread-result overrun. It sits between the GPS_PULSE pin, the counter datapath and the SPI slave, in the `system_clk[0]` domain.

## Interface
- `GATE_WIDTH`, default 4: width of the gate-length field. A gate spans `gate_len+1` PPS intervals.
- `TIMEOUT_CYCLES`, default 16777215: number of clk cycles without a PPS edge after which PPS is declared lost.
- `clk`  in  1: system clock. All logic is on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `pps_in`  in  1: raw, asynchronous GPS PPS pin.
- `measure_en`  in  1: level input. 0 forces IDLE.
- `gate_len`  in  GATE_WIDTH: requested gate length. Sampled only at gate start.
- `result_ack`  in  1: single-cycle strobe from SPI meaning the result has been read.
- `cnt_saturated`  in  1: the counter has reached all-ones.
- `cnt_clear`  out  1: single-cycle strobe that zeroes the counter.
- `cnt_en`  out  1: counter increment enable.
- `cnt_latch`  out  1: single-cycle strobe; the datapath copies the counter into its result register.
- `result_valid`  out  1: a latched result is waiting to be read.
- `result_saturated`  out  1: the counter saturated during the gate that produced the current result.
- `overrun`  out  1: sticky flag; a result was overwritten before it was acked.
- `pps_lost`  out  1: sticky flag; the PPS timeout expired.
- `gate_pos`  out  GATE_WIDTH: number of PPS intervals completed in the current gate.

## Operation
- PPS front end:
  - Two-FF synchronizer followed by one history FF.
  - `pps_edge` is 1 for exactly one cycle when sync=1 and history=0.
- States are IDLE, RUN and HOLDOVER. Reset enters IDLE.
- IDLE:
  - `cnt_en`=0.
  - On `pps_edge` with `measure_en`=1: go to RUN, pulse `cnt_clear`, load `gate_len` into an internal `gate_cur`, set `gate_pos`=0, clear `pps_lost`.
- RUN:
  - `cnt_en`=1.
  - On `pps_edge` with `gate_pos`==`gate_cur`: end of gate.
    - Pulse `cnt_latch` and `cnt_clear` in the same cycle. The datapath latches before clearing.
    - Set `result_valid`.
    - Capture `result_saturated` from the internal saturation-seen flag, then clear that flag.
    - Reload `gate_cur` from `gate_len` and set `gate_pos`=0.
  - On `pps_edge` otherwise: `gate_pos`+1.
  - `cnt_saturated`=1 sets the saturation-seen flag.
- Timeout counter:
  - Cleared on every `pps_edge` and whenever the state is not RUN.
  - Saturates at TIMEOUT_CYCLES.
  - When it reaches TIMEOUT_CYCLES in RUN: go to HOLDOVER, set `pps_lost`, set `cnt_en`=0. The partial gate is discarded with no latch.
- HOLDOVER:
  - `cnt_en`=0.
  - On `pps_edge` with `measure_en`=1: behave exactly as the IDLE→RUN transition.
- `measure_en`=0 in any state:
  - Next state is IDLE and `cnt_en`=0 next cycle. No latch.
  - `result_valid` and the flags are untouched.
- Handshake:
  - `result_ack` clears `result_valid` and `overrun`.
  - Latch while `result_valid`=1 and no ack in the same cycle: `overrun` is set and `result_valid` stays 1.
  - Latch and ack in the same cycle: `result_valid`=1 and `overrun`=0 (the ack consumes the old value).
  - Ack while `result_valid`=0 has no effect.
- `pps_lost` clears only on restart into RUN or on reset.

## Timing
- Reset values: all outputs 0, state IDLE, synchronizer 0.
- Pin rise to `pps_edge`: 2–3 cycles. `pps_edge` to the strobes: 1 cycle. All outputs are registered.
- `cnt_en` rises in the same cycle as the first `cnt_clear`. The first counted cycle is the one after the clear.
- Gate length in cycles equals the distance between consecutive latch strobes. No cycles are lost: the latch+clear cycle itself counts as 0.
- Timeout declared exactly TIMEOUT_CYCLES cycles after the last `pps_edge`.
- A `pps_edge` in the same cycle as the timeout expiring wins: the edge is processed and no HOLDOVER is entered.
- `gate_len` changes mid-gate take effect at the next gate start.
- Reset asserted mid-gate: immediate return to reset values. No strobes are generated.

## Test plan
- TIMEOUT_CYCLES=100, `gate_len`=0, PPS every 50 cycles: `cnt_clear` on the first edge, then `cnt_latch`+`cnt_clear` every 50 cycles, `result_valid`=1 after each.
- `gate_len`=2, PPS every 50 cycles: latch strobes 150 cycles apart, and `gate_pos` steps 0,1,2,0.
- No ack across two gates → `overrun`=1. Ack in the same cycle as the next latch → `result_valid`=1, `overrun`=0.
- PPS stops in RUN → `pps_lost`=1 and `cnt_en`=0 exactly 100 cycles after the last edge. The next PPS restarts with `cnt_clear` and `pps_lost`=0.
- `cnt_saturated` pulsed mid-gate → next result has `result_saturated`=1. The following clean gate → 0.
- `measure_en` dropped mid-gate → IDLE, no latch. `rst_n` low mid-gate → all outputs 0 asynchronously.

Source files
------------

// File: rtl/pps_gate_if.sv
// pps_gate_if: counter strobes and result handshake between the gate controller and the counter/SPI side
//   master: drives cnt_clear, cnt_en, cnt_latch, result_valid, result_saturated; samples cnt_saturated, result_ack
//   slave : the counter datapath / SPI register map side
interface pps_gate_if;
  logic cnt_clear;
  logic cnt_en;
  logic cnt_latch;
  logic cnt_saturated;
  logic result_valid;
  logic result_saturated;
  logic result_ack;
  modport master(
    output cnt_clear, cnt_en, cnt_latch, result_valid, result_saturated,
    input  cnt_saturated, result_ack
  );
  modport slave(
    input  cnt_clear, cnt_en, cnt_latch, result_valid, result_saturated,
    output cnt_saturated, result_ack
  );
endinterface

// File: rtl/pps_gate_controller.sv
// pps_gate_controller: opens/closes PPS-aligned measurement gates and hands latched results to SPI
//   clk, rst_n       : system clock, async active-low reset
//   pps_in           : raw asynchronous GPS 1PPS pin
//   measure_en       : level enable, 0 forces IDLE
//   gate_len         : gate spans gate_len+1 PPS intervals, sampled at gate start
//   bus              : counter strobes (clear/en/latch/saturated) and result valid/ack handshake
//   overrun, pps_lost: sticky status flags
//   gate_pos         : PPS intervals completed in the current gate
module pps_gate_controller #(
  parameter int GATE_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 16777215
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pps_in,
  input  logic                  measure_en,
  input  logic [GATE_WIDTH-1:0] gate_len,
  pps_gate_if.master            bus,
  output logic                  overrun,
  output logic                  pps_lost,
  output logic [GATE_WIDTH-1:0] gate_pos
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, RUN, HOLDOVER} state_t;
  state_t state, state_nx;
  logic sync0, sync1, hist, pps_edge;
  logic [TW-1:0] tmo, tmo_nx;
  logic [GATE_WIDTH-1:0] gate_cur, gate_cur_nx, gate_pos_nx;
  logic sat_seen, sat_seen_nx;
  logic start, gate_end, step, expire;
  logic clear_nx, latch_nx, en_nx, valid_nx, rsat_nx, overrun_nx, lost_nx;
  assign pps_edge = sync1 & ~hist;
  assign start    = state != RUN && measure_en && pps_edge;
  assign gate_end = state == RUN && measure_en && pps_edge && gate_pos == gate_cur;
  assign step     = state == RUN && measure_en && pps_edge && gate_pos != gate_cur;
  // Expiry is decided one cycle early so the registered outputs change exactly
  // TIMEOUT_CYCLES cycles after the strobes of the last edge; a coincident edge wins.
  assign expire   = state == RUN && measure_en && !pps_edge && tmo == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = !measure_en ? IDLE : start ? RUN : expire ? HOLDOVER : state;
  end
  always_comb begin
    clear_nx    = start | gate_end;
    latch_nx    = gate_end;
    en_nx       = state_nx == RUN;
    tmo_nx      = (pps_edge || state != RUN) ? '0 : tmo == TW'(TIMEOUT_CYCLES) ? tmo : tmo + TW'(1);
    gate_cur_nx = (start | gate_end) ? gate_len : gate_cur;
    gate_pos_nx = (start | gate_end) ? '0 : step ? gate_pos + GATE_WIDTH'(1) : gate_pos;
    sat_seen_nx = (start | gate_end) ? 1'b0 : (state == RUN && bus.cnt_saturated) ? 1'b1 : sat_seen;
    rsat_nx     = gate_end ? (sat_seen | bus.cnt_saturated) : bus.result_saturated;
    // The handshake follows the registered latch strobe, so an ack seen together
    // with cnt_latch consumes the previous result rather than the new one.
    valid_nx    = bus.cnt_latch | (bus.result_valid & ~bus.result_ack);
    overrun_nx  = ~(bus.result_ack & bus.result_valid) & (overrun | (bus.cnt_latch & bus.result_valid));
    lost_nx     = start ? 1'b0 : expire ? 1'b1 : pps_lost;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {sync0, sync1, hist} <= '0;
      tmo                  <= '0;
      gate_cur             <= '0;
      gate_pos             <= '0;
      sat_seen             <= 1'b0;
      bus.cnt_clear        <= 1'b0;
      bus.cnt_latch        <= 1'b0;
      bus.cnt_en           <= 1'b0;
      bus.result_valid     <= 1'b0;
      bus.result_saturated <= 1'b0;
      overrun              <= 1'b0;
      pps_lost             <= 1'b0;
    end else begin
      {sync0, sync1, hist} <= {pps_in, sync0, sync1};
      tmo                  <= tmo_nx;
      gate_cur             <= gate_cur_nx;
      gate_pos             <= gate_pos_nx;
      sat_seen             <= sat_seen_nx;
      bus.cnt_clear        <= clear_nx;
      bus.cnt_latch        <= latch_nx;
      bus.cnt_en           <= en_nx;
      bus.result_valid     <= valid_nx;
      bus.result_saturated <= rsat_nx;
      overrun              <= overrun_nx;
      pps_lost             <= lost_nx;
    end
endmodule
